// File: rtl/xsw_pkg.sv
// Shared constants and helpers for the xswitch_nxn crossbar.
// Statistics counters are controlled by the XSW_STATS_EN macro in xswitch_nxn.
package xsw_pkg;

    localparam int STAT_W = 16;

    // Width of a port index; never narrower than one bit.
    function automatic int xsw_dest_w(input int nports);
        return (nports > 1) ? $clog2(nports) : 1;
    endfunction

endpackage

// File: rtl/xsw_rr_arb.sv
// Round-robin arbiter: one-hot grant searched from ptr, ptr moves past the winner.
module xsw_rr_arb
    import xsw_pkg::*;
#(
    parameter int NPORTS = 4,
    localparam int DEST_W = xsw_dest_w(NPORTS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [NPORTS-1:0] req,
    output logic [NPORTS-1:0] gnt
);

    logic [DEST_W-1:0] ptr;
    logic [DEST_W-1:0] win;
    logic              hit;
    int                idx;

    always_comb begin
        gnt = '0;
        win = '0;
        hit = 1'b0;
        idx = 0;
        for (int k = 0; k < NPORTS; k++) begin
            idx = (int'(ptr) + k) % NPORTS;
            if (en && !hit && req[idx]) begin
                gnt[idx] = 1'b1;
                win      = DEST_W'(idx);
                hit      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (hit) begin
            ptr <= (win == DEST_W'(NPORTS - 1)) ? '0 : win + DEST_W'(1);
        end
    end

endmodule

// File: rtl/xswitch_nxn.sv
// NxN crossbar: per-output round-robin arbiter feeding a per-output in-order FIFO.
// Define XSW_STATS_EN to build the saturating per-output accepted-word counters.
module xswitch_nxn
    import xsw_pkg::*;
#(
    parameter int NPORTS     = 4,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    localparam int DEST_W    = xsw_dest_w(NPORTS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NPORTS-1:0]          in_valid,
    input  logic [NPORTS*DATA_W-1:0]   in_data,
    input  logic [NPORTS*DEST_W-1:0]   in_dest,
    output logic [NPORTS-1:0]          in_ready,
    output logic [NPORTS-1:0]          out_valid,
    output logic [NPORTS*DATA_W-1:0]   out_data,
    output logic [NPORTS*DEST_W-1:0]   out_src,
    input  logic [NPORTS-1:0]          out_ready,
    output logic [NPORTS*STAT_W-1:0]   stat_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [DEST_W-1:0] src;
    } xsw_word_t;

    logic [NPORTS-1:0] req [NPORTS];
    logic [NPORTS-1:0] gnt [NPORTS];
    logic [NPORTS-1:0] dest_bad;

    always_comb begin
        for (int o = 0; o < NPORTS; o++) begin
            req[o] = '0;
            for (int i = 0; i < NPORTS; i++) begin
                req[o][i] = in_valid[i] && (in_dest[i*DEST_W +: DEST_W] == DEST_W'(o));
            end
        end
    end

    // Out-of-range destinations only exist when NPORTS is not a power of two.
    for (genvar i = 0; i < NPORTS; i++) begin : g_bad
        if (NPORTS < (1 << DEST_W)) begin : g_chk
            assign dest_bad[i] = in_valid[i] && (int'(in_dest[i*DEST_W +: DEST_W]) >= NPORTS);
        end else begin : g_none
            assign dest_bad[i] = 1'b0;
        end
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NPORTS; i++) begin
            for (int o = 0; o < NPORTS; o++) begin
                if (gnt[o][i]) in_ready[i] = 1'b1;
            end
            if (dest_bad[i] && !reset) in_ready[i] = 1'b1;
        end
    end

    for (genvar o = 0; o < NPORTS; o++) begin : g_out
        xsw_word_t      mem [FIFO_DEPTH];
        xsw_word_t      wdata;
        logic [AW-1:0]  wr_ptr;
        logic [AW-1:0]  rd_ptr;
        logic [AW:0]    count;
        logic           full;
        logic           push;
        logic           pop;

        // Full is judged on the registered count, so a same-cycle pop never frees a slot.
        assign full = (count == (AW+1)'(FIFO_DEPTH));
        assign push = |gnt[o];
        assign pop  = out_valid[o] && out_ready[o];

        xsw_rr_arb #(.NPORTS(NPORTS)) u_arb (
            .clk   (clk),
            .reset (reset),
            .en    (!full && !reset),
            .req   (req[o]),
            .gnt   (gnt[o])
        );

        always_comb begin
            wdata = '0;
            for (int i = 0; i < NPORTS; i++) begin
                if (gnt[o][i]) begin
                    wdata.data = in_data[i*DATA_W +: DATA_W];
                    wdata.src  = DEST_W'(i);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (push) mem[wr_ptr] <= wdata;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                case ({push, pop})
                    2'b10:   count <= count + (AW+1)'(1);
                    2'b01:   count <= count - (AW+1)'(1);
                    default: count <= count;
                endcase
            end
        end

        assign out_valid[o]                   = (count != '0) && !reset;
        assign out_data[o*DATA_W +: DATA_W]   = mem[rd_ptr].data;
        assign out_src[o*DEST_W +: DEST_W]    = mem[rd_ptr].src;

`ifdef XSW_STATS_EN
        logic [STAT_W-1:0] cnt;

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt <= '0;
            end else if (push && (cnt != '1)) begin
                cnt <= cnt + STAT_W'(1);
            end
        end

        assign stat_cnt[o*STAT_W +: STAT_W] = cnt;
`else
        assign stat_cnt[o*STAT_W +: STAT_W] = '0;
`endif
    end

endmodule

// File: tb/tb_xswitch_nxn.sv
// Self-checking bench for xswitch_nxn (4 ports, 8-bit data, depth 4).
// Expected stat_cnt values follow the XSW_STATS_EN macro.
module tb_xswitch_nxn;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int DESTW = 2;
    localparam int SW    = 16;
`ifdef XSW_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      in_valid;
    logic [N*DW-1:0]   in_data;
    logic [N*DESTW-1:0] in_dest;
    logic [N-1:0]      in_ready;
    logic [N-1:0]      out_valid;
    logic [N*DW-1:0]   out_data;
    logic [N*DESTW-1:0] out_src;
    logic [N-1:0]      out_ready;
    logic [N*SW-1:0]   stat_cnt;

    always #5 clk = ~clk;

    xswitch_nxn #(.NPORTS(N), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .stat_cnt  (stat_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: accepted words queued per output, compared when popped.
    logic [DW+DESTW-1:0] exp_q [N][$];
    logic [DW+DESTW-1:0] sb_e;
    int                  sb_d;

    always @(negedge clk) begin
        if (reset) begin
            for (int o = 0; o < N; o++) exp_q[o].delete();
        end else begin
            for (int o = 0; o < N; o++) begin
                if (out_valid[o] && out_ready[o]) begin
                    if (exp_q[o].size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL sb_unexpected out%0d actual=%0h expected=none", o,
                                 {out_data[o*DW +: DW], out_src[o*DESTW +: DESTW]});
                    end else begin
                        sb_e = exp_q[o].pop_front();
                        check($sformatf("sb_out%0d", o),
                              64'({out_data[o*DW +: DW], out_src[o*DESTW +: DESTW]}), 64'(sb_e));
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                if (in_valid[i] && in_ready[i]) begin
                    sb_d = int'(in_dest[i*DESTW +: DESTW]);
                    exp_q[sb_d].push_back({in_data[i*DW +: DW], DESTW'(i)});
                end
            end
        end
    end

    typedef struct {
        logic [N-1:0]       v;
        logic [N*DESTW-1:0] dest;
        logic [N*DW-1:0]    data;
        logic [N-1:0]       ordy;
        logic [N-1:0]       exp_rdy;
        logic [N-1:0]       exp_ov;
    } vec_t;

    vec_t tbl [11];

    function automatic vec_t mk(input logic [N-1:0] v, input logic [N*DESTW-1:0] dest,
                                input logic [N*DW-1:0] data, input logic [N-1:0] rdy,
                                input logic [N-1:0] ov);
        vec_t r;
        r.v = v; r.dest = dest; r.data = data; r.ordy = 4'hF;
        r.exp_rdy = rdy; r.exp_ov = ov;
        return r;
    endfunction

    task automatic drive(input logic [N-1:0] v, input logic [N*DESTW-1:0] d,
                         input logic [N*DW-1:0] dat, input logic [N-1:0] ordy);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_dest   = d;
        in_data   = dat;
        out_ready = ordy;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n_long;
        logic [DW-1:0] r8;

        // Reset with every input requesting.
        reset = 1'b1; in_valid = '1; in_dest = 8'hE4; in_data = 32'h44332211; out_ready = '1;
        @(posedge clk);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("rst_in_ready", 64'(in_ready), 64'h0);
            check("rst_out_valid", 64'(out_valid), 64'h0);
            check("rst_stat", 64'(stat_cnt), 64'h0);
            @(posedge clk);
        end
        #1;
        reset = 1'b0; in_valid = '0;

        // Contention on out1 (ptr from 0), single path, parallel and mixed traffic.
        tbl[0]  = mk(4'b0000, 8'h00, 32'h0,        4'b0000, 4'b0000);
        tbl[1]  = mk(4'b1111, 8'h55, 32'h13121110, 4'b0001, 4'b0000);
        tbl[2]  = mk(4'b1111, 8'h55, 32'h13121110, 4'b0010, 4'b0010);
        tbl[3]  = mk(4'b1111, 8'h55, 32'h13121110, 4'b0100, 4'b0010);
        tbl[4]  = mk(4'b1111, 8'h55, 32'h13121110, 4'b1000, 4'b0010);
        tbl[5]  = mk(4'b1111, 8'h55, 32'h13121110, 4'b0001, 4'b0010);
        tbl[6]  = mk(4'b0001, 8'h02, 32'h000000A5, 4'b0001, 4'b0010);
        tbl[7]  = mk(4'b0011, 8'h01, 32'h00002120, 4'b0011, 4'b0100);
        tbl[8]  = mk(4'b1111, 8'h0F, 32'h33323130, 4'b0101, 4'b0011);
        tbl[9]  = mk(4'b0000, 8'h00, 32'h0,        4'b0000, 4'b1001);
        tbl[10] = mk(4'b0000, 8'h00, 32'h0,        4'b0000, 4'b0000);
        for (int t = 0; t < 11; t++) begin
            drive(tbl[t].v, tbl[t].dest, tbl[t].data, tbl[t].ordy);
            @(negedge clk);
            check($sformatf("tbl%0d_in_ready", t), 64'(in_ready), 64'(tbl[t].exp_rdy));
            check($sformatf("tbl%0d_out_valid", t), 64'(out_valid), 64'(tbl[t].exp_ov));
        end
        check("tbl_stat", 64'(stat_cnt), STATS ? 64'h0001_0001_0006_0002 : 64'h0);

        // Output 3 fills, refuses while full (even when popped), accepts after the pop.
        for (int c = 0; c < 8; c++) begin
            drive((c < 7) ? 4'b0001 : 4'b0000, 8'h03, 32'(8'h30 + ((c < 4) ? c : 4)),
                  (c == 5) ? 4'b1111 : 4'b0111);
            @(negedge clk);
            check($sformatf("full_c%0d_in_ready", c), 64'(in_ready),
                  (c < 4 || c == 6) ? 64'h1 : 64'h0);
            if (c == 4 || c == 5) begin
                check($sformatf("full_c%0d_head", c), 64'({out_valid[3], out_data[31:24], out_src[7:6]}),
                      64'({1'b1, 8'h30, 2'd0}));
            end
        end
        for (int c = 0; c < 6; c++) drive('0, '0, '0, '1);
        check("full_drained", 64'(exp_q[3].size()), 64'h0);

        // Reset with words buffered discards them.
        drive(4'b0001, 8'h03, 32'h51, 4'b0111);
        drive(4'b0001, 8'h03, 32'h51, 4'b0111);
        @(posedge clk); #1; reset = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 64'(in_ready), 64'h0);
        @(posedge clk); #1; reset = 1'b0; in_valid = '0;
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'h0);
        drive(4'b0001, 8'h03, 32'h52, 4'b0111);
        @(negedge clk);
        check("midrst_accept", 64'(in_ready), 64'h1);
        drive('0, '0, '0, 4'b0111);
        @(negedge clk);
        check("midrst_one_word", 64'({out_valid, out_data[31:24]}), 64'({4'b1000, 8'h52}));
        drive('0, '0, '0, '1);

        // Statistics: count, saturate, clear on reset.
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        check("stat_after_rst", 64'(stat_cnt), 64'h0);
        for (int k = 0; k < 10; k++) begin
            r8 = 8'($urandom_range(0, 255));
            drive(4'b0001, 8'h00, 32'(r8), '1);
        end
        drive('0, '0, '0, '1);
        @(negedge clk);
        check("stat_10", 64'(stat_cnt), STATS ? 64'd10 : 64'd0);
        n_long = STATS ? 69990 : 200;
        for (int k = 0; k < n_long; k++) begin
            r8 = 8'($urandom_range(0, 255));
            drive(4'b0001, 8'h00, 32'(r8), '1);
        end
        drive('0, '0, '0, '1);
        @(negedge clk);
        check("stat_sat", 64'(stat_cnt), STATS ? 64'hFFFF : 64'h0);
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        check("stat_cleared", 64'(stat_cnt), 64'h0);

        // Final drain: every accepted word must have come out.
        drive(4'b0110, 8'h1C, 32'h00C3B200, '1);
        for (int c = 0; c < 8; c++) drive('0, '0, '0, '1);
        for (int o = 0; o < N; o++) begin
            check($sformatf("end_q%0d_empty", o), 64'(exp_q[o].size()), 64'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
